dict_loader: RTL
================

// Module: dict_loader
// PURPOSE
//   Boot-time loader for the decompression dictionaries of the compressed-code cache controller.
//   - Fetches NUM_DICTS dictionaries from instruction memory over the imem valid/ready port.
//   - Layout: consecutive 32-bit words at BASE_ADDR, dict 0 first.
//   - Writes each entry into its dictionary through a shared indexed write bus.
//   - Holds the core in reset (proc_resetn=0) until every dictionary is loaded.
// PARAMETERS
//   NUM_DICTS    3                         number of dictionaries, 1..4
//   KEY_WIDTH    8                         index width; max dictionary depth is 2**KEY_WIDTH
//   VAL_WIDTH    15                        entry width; entry = low VAL_WIDTH bits of fetched word
//   DICT_DEPTHS  {16'd256,16'd32,16'd8}    depth of dict i = DICT_DEPTHS[16*i +: 16], each 1..2**KEY_WIDTH
//   BASE_ADDR    32'h0001_0000             word-aligned address of first entry
//   AUTO_START   1                         1: start loading in the first cycle out of reset
// PORTS
//   clk                in   1          clock
//   reset              in   1          synchronous, active-high reset
//   start              in   1          one-cycle pulse; (re)load request
//   mem_req_valid      out  1          fetch request to imem
//   mem_req_ready      in   1          imem handshake; rdata valid in the same cycle
//   mem_req_addr       out  32         fetch address
//   mem_req_rdata      in   32         fetched word
//   dict_write_enable  out  NUM_DICTS  one-hot write strobe, bit i = dict i
//   dict_write_idx     out  KEY_WIDTH  entry index within the selected dict
//   dict_write_val     out  VAL_WIDTH  entry value
//   busy               out  1          load in progress
//   done               out  1          all dictionaries loaded
//   proc_resetn        out  1          core reset release, active-low
//   checksum_err       out  1          checksum mismatch (see CONFIGURATION)
// BEHAVIOUR
//   - Reset values (next edge with reset=1):
//       mem_req_valid=0, mem_req_addr=BASE_ADDR, dict_write_enable=0, idx=0, val=0,
//       busy=0, done=0, proc_resetn=0, checksum_err=0, state=IDLE.
//     Reset mid-load aborts the load with no further writes.
//   - States IDLE -> REQ -> WR -> (REQ | [CHK] | DONE).
//   - IDLE:
//       (AUTO_START && first cycle after reset) or start -> REQ, busy=1.
//   - REQ:
//       mem_req_valid=1, addr held stable until the cycle mem_req_ready=1.
//       In that cycle rdata is captured; valid drops at the next edge; state -> WR.
//   - WR (exactly 1 cycle):
//       dict_write_enable[d]=1, idx=k, val=rdata[VAL_WIDTH-1:0]; addr += 4.
//       k+1 < depth(d): k++.
//       Else: d++, k=0; after the last dict -> DONE (or CHK).
//   - Throughput: zero-wait imem gives 2 cycles/entry.
//       Total entries N = sum of depths (default 296).
//       done rises in cycle 2N+1, counting the first cycle after reset release as 0.
//   - DONE:
//       busy=0, done=1, proc_resetn = done && !checksum_err.
//       start -> restart at BASE_ADDR, d=0, k=0; done and proc_resetn drop 1 cycle later.
//   - start while busy is ignored. start and mem_req_ready in the same cycle: handshake wins, start dropped.
//   - dict_write_enable is never asserted outside WR; at most one bit is set.
//   - Address increment wraps modulo 2**32; no alignment checking.
// CONFIGURATION
//   DICT_LOADER_CHECKSUM_EN
//     Defined:
//       - After the last entry, one extra word is fetched at the next address (state CHK).
//       - It is compared with the 32-bit wrap-around sum of all N raw fetched words.
//       - Mismatch: checksum_err=1 (held until reset/restart), done=1, proc_resetn stays 0.
//       - done rises at cycle 2N+2 on zero-wait imem.
//     Undefined:
//       - No CHK state or extra fetch; checksum_err is constant 0.
// TESTING
//   1. Default params, zero-wait imem, reset released -> 296 writes:
//        dict0 idx 0..7, dict1 0..31, dict2 0..255; addrs 0x10000..0x1049C.
//        done=proc_resetn=1 at cycle 593.
//   2. imem ready after 3 cycles each -> valid/addr stable while waiting.
//        Exactly one write per handshake; 5 cycles/entry.
//   3. reset=1 during entry 100 -> all outputs at reset values next edge.
//        After release, reload starts at 0x10000 with dict0 idx 0.
//   4. start pulse while busy -> ignored, write sequence unchanged.
//        start pulse in DONE -> done=0 next cycle, full reload, done=1 again.
//   5. rdata=0xFFFF_ABCD, VAL_WIDTH=15 -> dict_write_val=15'h2BCD.
//   6. With DICT_LOADER_CHECKSUM_EN:
//        correct sum word -> checksum_err=0, proc_resetn=1.
//        sum+1 -> checksum_err=1, done=1, proc_resetn=0.

Source files
------------

// File: rtl/dict_loader.sv
// dict_loader
//   Boot-time loader for the decompression dictionaries of the compressed-code
//   cache controller. Streams NUM_DICTS dictionaries from instruction memory
//   (consecutive 32-bit words starting at BASE_ADDR, dict 0 first) and writes
//   each entry through a shared indexed write bus. Holds the core in reset
//   until every dictionary has been loaded.
//
//   Optional feature macro: DICT_LOADER_CHECKSUM_EN
//     When defined, one extra word following the last entry is fetched and
//     compared against the 32-bit wrap-around sum of all fetched entry words.
//     A mismatch raises checksum_err and keeps proc_resetn low.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   start              one-cycle (re)load request, ignored while busy
//   mem_req_*          imem valid/ready fetch port, rdata valid with ready
//   dict_write_*       one-hot dictionary strobe, entry index, entry value
//   busy, done         load in progress / all dictionaries loaded
//   proc_resetn        core reset release (active low)
//   checksum_err       checksum mismatch (constant 0 without the feature)
module dict_loader #(
    parameter int                    NUM_DICTS   = 3,
    parameter int                    KEY_WIDTH   = 8,
    parameter int                    VAL_WIDTH   = 15,
    parameter logic [16*NUM_DICTS-1:0] DICT_DEPTHS = {16'd256, 16'd32, 16'd8},
    parameter logic [31:0]           BASE_ADDR   = 32'h0001_0000,
    parameter bit                    AUTO_START  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [31:0]          mem_req_addr,
    input  logic [31:0]          mem_req_rdata,
    output logic [NUM_DICTS-1:0] dict_write_enable,
    output logic [KEY_WIDTH-1:0] dict_write_idx,
    output logic [VAL_WIDTH-1:0] dict_write_val,
    output logic                 busy,
    output logic                 done,
    output logic                 proc_resetn,
    output logic                 checksum_err
);

    localparam int DW = (NUM_DICTS > 1) ? $clog2(NUM_DICTS) : 1;
    localparam logic [DW-1:0] LAST_D = DW'(NUM_DICTS - 1);

    typedef enum logic [2:0] {IDLE, REQ, WR, CHK, DONE} state_t;

    state_t               state, state_nxt;
    logic [31:0]          addr_q;
    logic [DW-1:0]        d_q;
    logic [KEY_WIDTH-1:0] k_q;
    logic [VAL_WIDTH-1:0] val_q;
    logic                 first_q;   // high only in the first cycle out of reset
    logic [15:0]          cur_depth;
    logic [31:0]          k_inc;
    logic                 last_entry;
    logic                 last_dict;
    logic                 launch;

`ifdef DICT_LOADER_CHECKSUM_EN
    logic [31:0]          sum_q;
    logic                 err_q;
`endif

    // Depth of the dictionary currently being filled.
    always_comb begin
        cur_depth = 16'd0;
        for (int i = 0; i < NUM_DICTS; i++) begin
            if (d_q == DW'(i)) cur_depth = DICT_DEPTHS[16*i +: 16];
        end
    end

    assign k_inc      = 32'(k_q) + 32'd1;
    assign last_entry = (k_inc >= 32'(cur_depth));
    assign last_dict  = (d_q == LAST_D);

    // A load begins from IDLE (auto-start or explicit start) or restarts from
    // DONE on start. start in any busy state is dropped.
    assign launch = ((state == IDLE) && ((AUTO_START && first_q) || start)) ||
                    ((state == DONE) && start);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                busy          = 1'b1;
                if (mem_req_ready) state_nxt = WR;
            end
            WR: begin
                busy = 1'b1;
                if (last_entry && last_dict) begin
`ifdef DICT_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = REQ;
                end
            end
`ifdef DICT_LOADER_CHECKSUM_EN
            CHK: begin
                mem_req_valid = 1'b1;
                busy          = 1'b1;
                if (mem_req_ready) state_nxt = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: fetch address, dict/entry counters, captured entry value
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= BASE_ADDR;
            d_q     <= '0;
            k_q     <= '0;
            val_q   <= '0;
            first_q <= 1'b1;
`ifdef DICT_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            first_q <= 1'b0;
            if (launch) begin
                addr_q <= BASE_ADDR;
                d_q    <= '0;
                k_q    <= '0;
`ifdef DICT_LOADER_CHECKSUM_EN
                sum_q  <= '0;
                err_q  <= 1'b0;
`endif
            end
            case (state)
                REQ: begin
                    if (mem_req_ready) begin
                        val_q <= mem_req_rdata[VAL_WIDTH-1:0];
`ifdef DICT_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + mem_req_rdata;
`endif
                    end
                end
                WR: begin
                    addr_q <= addr_q + 32'd4;   // wraps modulo 2**32
                    if (last_entry) begin
                        k_q <= '0;
                        d_q <= last_dict ? '0 : d_q + DW'(1);
                    end else begin
                        k_q <= k_q + KEY_WIDTH'(1);
                    end
                end
`ifdef DICT_LOADER_CHECKSUM_EN
                CHK: begin
                    if (mem_req_ready) err_q <= (mem_req_rdata != sum_q);
                end
`endif
                default: ;
            endcase
        end
    end

    assign mem_req_addr      = addr_q;
    assign dict_write_enable = (state == WR) ? (NUM_DICTS'(1) << d_q) : '0;
    assign dict_write_idx    = k_q;
    assign dict_write_val    = val_q;

`ifdef DICT_LOADER_CHECKSUM_EN
    assign checksum_err = err_q;
`else
    assign checksum_err = 1'b0;
    // Only the low VAL_WIDTH bits of a fetched word matter without the checksum.
    if (VAL_WIDTH < 32) begin : g_rdata_unused
        logic rdata_unused;
        assign rdata_unused = ^mem_req_rdata[31:VAL_WIDTH];
    end
`endif

    assign proc_resetn = done && !checksum_err;

endmodule
